x_valid_monitor: RTL and testbench

X_VALID_MONITOR -- requirements
Module: x_valid_monitor

---
 rtl/xmon_pkg.sv | 13 +
 rtl/xmon_sat_cnt.sv | 24 ++
 rtl/x_valid_monitor.sv | 160 ++++++++++++++++
 tb/tb_x_valid_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xmon_pkg.sv
// Shared types and default constants for the X/valid channel monitor.
package xmon_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    TIMEOUT = 2'd2
  } xmon_state_e;

endpackage

// File: rtl/xmon_sat_cnt.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module xmon_sat_cnt
  import xmon_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/x_valid_monitor.sv
// Valid/ready channel monitor: X/Z detection on valid beats, beat counting, stall protocol checks.
// Define XMON_FATAL_EN to stop simulation on the first X beat or first protocol error.
//
// state   | meaning
// IDLE    | no outstanding stall; waiting for valid && !ready
// STALL   | valid held without ready; data must stay equal to the captured beat
// TIMEOUT | stall lasted TIMEOUT cycles; protocol checks still active
module x_valid_monitor
  import xmon_pkg::CNT_W_DEF, xmon_pkg::TIMEOUT_DEF, xmon_pkg::xmon_state_e,
         xmon_pkg::IDLE, xmon_pkg::STALL;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid,
  input  logic             ready,
  input  logic [WIDTH-1:0] inp,
  input  logic             clear,
  output logic             x_seen,
  output logic [CNT_W-1:0] x_count,
  output logic [WIDTH-1:0] first_x_mask,
  output logic [CNT_W-1:0] beat_count,
  output logic             protocol_err,
  output logic             stall_timeout
);

  // TIMEOUT must be at least 2: the IDLE cycle that opens a stall is stall cycle 1.
  localparam int SW = $clog2(TIMEOUT) + 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 2);

  xmon_state_e      state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] beat_mask;
  logic [SW-1:0]    stall_cnt;
  logic             v_one, v_x, r_one;
  logic             x_beat, xfer;
  logic             perr_evt, to_evt, cap_hold;
  logic             stall_clr, stall_inc;

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (inp[i] !== 1'b0) && (inp[i] !== 1'b1);
    end
  end

  // An unknown valid is itself an offending beat, reported as all bits bad.
  assign v_one     = (valid === 1'b1);
  assign v_x       = (valid !== 1'b0) && (valid !== 1'b1);
  assign r_one     = (ready === 1'b1);
  assign beat_mask = v_x ? '1 : mask;
  assign x_beat    = v_x || (v_one && (mask != '0));
  assign xfer      = v_one && r_one;

  always_comb begin
    state_d  = state_q;
    perr_evt = 1'b0;
    to_evt   = 1'b0;
    cap_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_one && !r_one) begin
          state_d  = STALL;
          cap_hold = 1'b1;
        end
      end
      STALL, xmon_pkg::TIMEOUT: begin
        if (!v_one) begin
          perr_evt = 1'b1;
          state_d  = IDLE;
        end else begin
          if (inp !== hold_q) perr_evt = 1'b1;
          if (r_one) begin
            state_d = IDLE;
          end else if ((state_q == STALL) && (stall_cnt == STALL_LAST)) begin
            state_d = xmon_pkg::TIMEOUT;
            to_evt  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cap_hold) hold_q <= inp;
    end
  end

  assign stall_clr = (state_q == IDLE);
  assign stall_inc = (state_q == STALL);

  xmon_sat_cnt #(.W(SW)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (stall_clr),
    .inc     (stall_inc),
    .count   (stall_cnt)
  );

  xmon_sat_cnt #(.W(CNT_W)) u_x_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (x_beat),
    .count   (x_count)
  );

  xmon_sat_cnt #(.W(CNT_W)) u_beat_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (xfer),
    .count   (beat_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_seen        <= 1'b0;
      first_x_mask  <= '0;
      protocol_err  <= 1'b0;
      stall_timeout <= 1'b0;
    end else if (clear) begin
      x_seen        <= 1'b0;
      first_x_mask  <= '0;
      protocol_err  <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      if (x_beat) begin
        x_seen <= 1'b1;
        if (!x_seen) first_x_mask <= beat_mask;
      end
      if (perr_evt) protocol_err  <= 1'b1;
      if (to_evt)   stall_timeout <= 1'b1;
    end
  end

`ifdef XMON_FATAL_EN
  always_ff @(posedge clock) begin
    if (reset_n && !clear) begin
      if (x_beat && !x_seen)
        $fatal(1, "x_valid_monitor: X/Z beat at %0t mask %h", $time, beat_mask);
      if (perr_evt && !protocol_err)
        $fatal(1, "x_valid_monitor: protocol error at %0t mask %h", $time, beat_mask);
    end
  end
`else
  // Silent build: status flags only.
`endif

endmodule

// File: tb/tb_x_valid_monitor.sv
// Scoreboard bench for x_valid_monitor: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_x_valid_monitor;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int T  = 1024;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid   = 1'b0;
  logic          ready   = 1'b0;
  logic          clear   = 1'b0;
  logic [W-1:0]  inp     = '0;
  logic          x_seen;
  logic [CW-1:0] x_count;
  logic [W-1:0]  first_x_mask;
  logic [CW-1:0] beat_count;
  logic          protocol_err;
  logic          stall_timeout;

  x_valid_monitor #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(T)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .valid         (valid),
    .ready         (ready),
    .inp           (inp),
    .clear         (clear),
    .x_seen        (x_seen),
    .x_count       (x_count),
    .first_x_mask  (first_x_mask),
    .beat_count    (beat_count),
    .protocol_err  (protocol_err),
    .stall_timeout (stall_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            tgt;
    string         name;
    logic          xs;
    logic [CW-1:0] xc;
    logic [W-1:0]  fm;
    logic [CW-1:0] bc;
    logic          pe;
    logic          to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  logic          e_xs, e_pe, e_to;
  logic [CW-1:0] e_xc, e_bc;
  logic [W-1:0]  e_fm;
  logic          four_st;
  logic          probe;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [W-1:0] d, input logic c);
    valid = v;
    ready = r;
    inp   = d;
    clear = c;
  endtask

  task automatic zero_exp();
    e_xs = 1'b0; e_xc = '0; e_fm = '0; e_bc = '0; e_pe = 1'b0; e_to = 1'b0;
  endtask

  task automatic expect_at(input string name, input int dly);
    exp_t e;
    e.tgt = cyc + dly;
    e.name = name;
    e.xs = e_xs; e.xc = e_xc; e.fm = e_fm; e.bc = e_bc; e.pe = e_pe; e.to = e_to;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clock or chk_now);
      while ((q.size() > 0) && (q[0].tgt <= cyc)) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({x_seen, x_count, first_x_mask, beat_count, protocol_err, stall_timeout} !==
            {e.xs, e.xc, e.fm, e.bc, e.pe, e.to}) begin
          errors++;
          $display("FAIL %s cyc %0d: got xs=%b xc=%0d fm=%h bc=%0d pe=%b to=%b, want xs=%b xc=%0d fm=%h bc=%0d pe=%b to=%b",
                   e.name, cyc, x_seen, x_count, first_x_mask, beat_count, protocol_err, stall_timeout,
                   e.xs, e.xc, e.fm, e.bc, e.pe, e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    probe   = 1'bx;
    four_st = (probe !== 1'b0) && (probe !== 1'b1);
    zero_exp();

    step(2);
    reset_n = 1'b1;
    expect_at("reset", 0);

    // X nibble on a completed transfer
    drive(1, 1, 32'h0000_00X0, 0);
    e_xs = four_st; e_xc = four_st ? 16'd1 : 16'd0; e_fm = four_st ? 32'h0000_00F0 : 32'h0;
    e_bc = 16'd1;
    expect_at("x_beat", 1);
    step();

    // second offending beat must not overwrite the first mask
    drive(1, 1, 32'hX000_0000, 0);
    e_xs = four_st; e_xc = four_st ? 16'd2 : 16'd0; e_bc = 16'd2;
    expect_at("first_mask_kept", 1);
    step();

    drive(0, 0, {W{1'bx}}, 1);
    zero_exp();
    expect_at("clear", 1);
    step();

    drive(0, 0, {W{1'bx}}, 0);
    step(10);
    expect_at("x_ignored_when_invalid", 0);

    drive(1, 1, {W{1'bx}}, 1);
    expect_at("clear_beats_x", 1);
    step();

    drive(1, 1, 32'h0000_1234, 0);
    step(3);
    e_bc = 16'd3;
    expect_at("clean_beats", 0);

    drive(0, 1, 32'h0000_1234, 0);
    step(2);
    expect_at("ready_only_no_beat", 0);

    // stall timeout
    drive(0, 0, 32'h0, 1);
    zero_exp();
    expect_at("clear_before_stall", 1);
    step();
    drive(1, 0, 32'h5, 0);
    expect_at("stall_before_timeout", T - 1);
    e_to = 1'b1;
    expect_at("stall_timeout", T);
    step(T + 3);
    drive(1, 1, 32'h5, 0);
    e_bc = 16'd1;
    expect_at("timeout_exit_beat", 1);
    step();
    drive(0, 0, 32'h0, 0);
    step();

    // data change during stall
    drive(0, 0, 32'h0, 1);
    zero_exp();
    expect_at("clear_before_change", 1);
    step();
    drive(1, 0, 32'h5, 0);
    expect_at("stall_entry_clean", 1);
    step();
    drive(1, 0, 32'h6, 0);
    e_pe = 1'b1;
    expect_at("inp_changed_in_stall", 1);
    step();
    drive(0, 1, 32'h0, 0);
    step();

    // valid dropped during stall
    drive(0, 0, 32'h0, 1);
    zero_exp();
    step();
    drive(1, 0, 32'h7, 0);
    step(2);
    drive(0, 0, 32'h7, 0);
    e_pe = 1'b1;
    expect_at("valid_dropped", 1);
    step();
    drive(0, 0, 32'h0, 1);
    zero_exp();
    step();
    // a fresh stall with new data only passes cleanly if the FSM returned to IDLE
    drive(1, 0, 32'h9, 0);
    step(3);
    drive(1, 1, 32'h9, 0);
    e_bc = 16'd1;
    expect_at("idle_after_drop", 1);
    step();
    drive(0, 0, 32'h0, 0);
    step();

    // asynchronous reset in the middle of a stall
    drive(0, 0, 32'h0, 1);
    zero_exp();
    step();
    drive(1, 1, 32'h1, 0);
    e_bc = 16'd1;
    step();
    drive(1, 0, 32'h3, 0);
    step(2);
    drive(1, 0, 32'h4, 0);
    e_pe = 1'b1;
    expect_at("pre_reset_state", 1);
    step(3);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    zero_exp();
    expect_at("async_reset", 0);
    -> chk_now;
    step(2);
    reset_n = 1'b1;
    expect_at("post_reset_stall_entry", 1);
    step();
    drive(1, 0, 32'h8, 0);
    e_pe = 1'b1;
    expect_at("post_reset_stall_checked", 1);
    step();
    drive(1, 1, 32'h8, 0);
    e_bc = 16'd1;
    expect_at("post_reset_exit", 1);
    step();
    drive(0, 0, 32'h0, 0);

    step(5);
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      errors += q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
